// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } chan_state_t;

endpackage

// File: rtl/demux_channel_buffer.sv
// One output channel: 2-entry FIFO (head + tail registers) with valid/ready output.
// Optional delivered-word counter when DEMUX_COUNT_EN is defined.
module demux_channel_buffer
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  chan_state_t      state_p1;
  chan_state_t      state_nxt;
  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] tail_p1;
  logic             pop;
  logic             load_head;
  logic             head_from_tail;
  logic             load_tail;

  assign out_valid = (state_p1 != EMPTY);
  assign full      = (state_p1 == FULL);
  assign out_data  = head_p1;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt      = state_p1;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    unique case (state_p1)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        // Push with a simultaneous pop replaces the head in place.
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: channel state and head word (head cleared on reset so outputs read zero)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= EMPTY;
      head_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (load_head) head_p1 <= head_from_tail ? tail_p1 : push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (load_tail) tail_p1 <= push_data;
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) out_count <= '0;
    else if (pop) out_count <= out_count + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/two_to_one_demux_buffered.sv
// Registered 1-to-2 stream demux: steers each input word to channel in_sel.
// Define DEMUX_COUNT_EN to add per-channel delivered-word counters.
module two_to_one_demux_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
`endif
);

  logic full0;
  logic full1;
  logic accept;

  // Ready depends only on the selected channel's occupancy, never on consumer ready.
  assign in_ready = in_sel ? !full1 : !full0;
  assign accept   = in_valid && in_ready;

  demux_channel_buffer #(.WIDTH(WIDTH)) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && !in_sel),
    .push_data (in_data),
    .full      (full0),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out_count (out0_count)
`endif
  );

  demux_channel_buffer #(.WIDTH(WIDTH)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && in_sel),
    .push_data (in_data),
    .full      (full1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out_count (out1_count)
`endif
  );

endmodule

// File: tb/tb_two_to_one_demux_buffered.sv
// Scoreboard bench for two_to_one_demux_buffered: driver queues expected words,
// a negedge monitor checks every output handshake against the queues.
module tb_two_to_one_demux_buffered;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sel;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
  logic [3:0] out0_data, out1_data;
`ifdef DEMUX_COUNT_EN
  logic [7:0] out0_count, out1_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  two_to_one_demux_buffered #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic s, input logic exp_acc, input string nm);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    #1;
    chk(nm, 32'(in_ready), 32'(exp_acc));
    if (exp_acc) begin
      if (s) q1.push_back(d);
      else q0.push_back(d);
    end
  endtask

  // Monitor: every completed output handshake must match the next queued word.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
        if (q0.size() == 0) chk("ch0_spurious", 32'(out0_data), 32'hFFFF);
        else chk("ch0_data", 32'(out0_data), 32'(q0.pop_front()));
      end
      if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
        if (q1.size() == 0) chk("ch1_spurious", 32'(out1_data), 32'hFFFF);
        else chk("ch1_data", 32'(out1_data), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset / idle
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_v1", 32'(out1_valid), 0);
    chk("rst_d0", 32'(out0_data), 0);
    chk("rst_d1", 32'(out1_data), 0);
    chk("rst_rdy0", 32'(in_ready), 1);
    in_sel = 1'b1; #1;
    chk("rst_rdy1", 32'(in_ready), 1);
`ifdef DEMUX_COUNT_EN
    chk("rst_cnt0", 32'(out0_count), 0);
    chk("rst_cnt1", 32'(out1_count), 0);
`endif

    // Alternating channels, consumers ready
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(4'hA, 1'b0, 1'b1, "alt_rdyA");
    tick();
    chk("alt_v0", 32'(out0_valid), 1);
    chk("alt_d0", 32'(out0_data), 32'hA);
    drive(4'h5, 1'b1, 1'b1, "alt_rdy5");
    tick();
    in_valid = 1'b0;
    chk("alt_v1", 32'(out1_valid), 1);
    chk("alt_d1", 32'(out1_data), 32'h5);
    chk("alt_v0_drained", 32'(out0_valid), 0);
    tick();
    chk("alt_v1_drained", 32'(out1_valid), 0);
`ifdef DEMUX_COUNT_EN
    chk("alt_cnt0", 32'(out0_count), 1);
    chk("alt_cnt1", 32'(out1_count), 1);
`endif

    // Sustained stream to channel 1: ready never drops
    for (int i = 0; i < 4; i++) begin
      drive(4'(8 + i), 1'b1, 1'b1, "stream_rdy");
      tick();
      chk("stream_d1", 32'(out1_data), 32'(8 + i));
    end
    in_valid = 1'b0;
    tick();

    // Fill channel 0 with consumer stalled
    out0_ready = 1'b0;
    drive(4'h1, 1'b0, 1'b1, "fill_rdy1");
    tick();
    drive(4'h2, 1'b0, 1'b1, "fill_rdy2");
    tick();
    drive(4'h3, 1'b0, 1'b0, "fill_rdy3_blocked");
    tick();
    chk("full_d0", 32'(out0_data), 32'h1);

    // Other channel still accepts while channel 0 is full
    drive(4'h7, 1'b1, 1'b1, "other_rdy7");
    tick();
    chk("other_v1", 32'(out1_valid), 1);
    chk("other_d1", 32'(out1_data), 32'h7);
    chk("other_v0", 32'(out0_valid), 1);
    chk("other_d0", 32'(out0_data), 32'h1);

    // Draining: FULL blocks push even while popping; then push+pop in ONE
    out0_ready = 1'b1;
    drive(4'h3, 1'b0, 1'b0, "full_pop_blocked");
    tick();
    chk("one_d0", 32'(out0_data), 32'h2);
    drive(4'h3, 1'b0, 1'b1, "one_rdy3");
    tick();
    in_valid = 1'b0;
    chk("pushpop_v0", 32'(out0_valid), 1);
    chk("pushpop_d0", 32'(out0_data), 32'h3);
    tick();
    chk("drain_v0", 32'(out0_valid), 0);

    // Fill both channels, then reset
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(4'hC, 1'b0, 1'b1, "rf_c"); tick();
    drive(4'hD, 1'b0, 1'b1, "rf_d"); tick();
    drive(4'hE, 1'b1, 1'b1, "rf_e"); tick();
    drive(4'hF, 1'b1, 1'b1, "rf_f"); tick();
    in_valid = 1'b0;
    chk("rf_d0", 32'(out0_data), 32'hC);
    chk("rf_d1", 32'(out1_data), 32'hE);
    in_sel = 1'b0; #1;
    chk("rf_full0", 32'(in_ready), 0);
    in_sel = 1'b1; #1;
    chk("rf_full1", 32'(in_ready), 0);
    rst = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    q0.delete(); q1.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_v0", 32'(out0_valid), 0);
    chk("mid_rst_v1", 32'(out1_valid), 0);
    chk("mid_rst_d0", 32'(out0_data), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
`ifdef DEMUX_COUNT_EN
    chk("mid_rst_cnt0", 32'(out0_count), 0);
    chk("mid_rst_cnt1", 32'(out1_count), 0);
`endif

    // 256 deliveries on channel 1
    for (int i = 0; i < 256; i++) begin
      drive(4'(i), 1'b1, 1'b1, "wrap_rdy");
      tick();
    end
`ifdef DEMUX_COUNT_EN
    chk("wrap_cnt255", 32'(out1_count), 255);
`endif
    in_valid = 1'b0;
    tick();
    chk("wrap_v1", 32'(out1_valid), 0);
`ifdef DEMUX_COUNT_EN
    chk("wrap_cnt0", 32'(out1_count), 0);
    chk("wrap_cnt_other", 32'(out0_count), 0);
`endif

    tick(); tick();
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
